jtcop_objdma: RTL and testbench

JTCOP_OBJDMA -- requirements
Module: jtcop_objdma

---
 rtl/jtcop_objdma.sv | 81 ++++++++
 tb/tb_jtcop_objdma.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_objdma.sv
// Object-RAM to sprite-buffer DMA: copies 2**AW words per copy-strobe edge, optionally held off until vblank.
// Latency: first write 2 cycles after start, busy for 2**AW+1 cycles; no backpressure, the buffer takes every write.
module jtcop_objdma #(
    parameter int AW      = 10,
    parameter bit WAIT_VB = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          copy,
    input  logic          LVBL,
    output logic [AW-1:0] src_addr,
    input  logic [15:0]   src_data,
    output logic [AW-1:0] dst_addr,
    output logic [15:0]   dst_dout,
    output logic          dst_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, WAIT, COPY, FLUSH} state_t;

    state_t      state, nx_state;
    logic        copy_l;
    logic        pending;
    logic        copy_edge;
    logic        go;
    logic        start;
    logic [15:0] dout_hold;

    assign copy_edge = copy & ~copy_l;
    assign go        = !WAIT_VB || !LVBL;
    assign start     = (nx_state == COPY) && (state != COPY);

    always_comb begin
        nx_state = state;
        case (state)
            IDLE:  if (pending) nx_state = go ? COPY : WAIT;
            WAIT:  if (go) nx_state = COPY;
            COPY:  if (src_addr == '1) nx_state = FLUSH;
            FLUSH: nx_state = IDLE;
            default: nx_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            copy_l    <= 1'b0;
            pending   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dst_we    <= 1'b0;
            src_addr  <= '0;
            dst_addr  <= '0;
            dout_hold <= 16'd0;
        end else begin
            state  <= nx_state;
            copy_l <= copy;
            // A new edge wins over the clear that happens on COPY entry
            if (copy_edge)
                pending <= 1'b1;
            else if (start)
                pending <= 1'b0;
            busy   <= (nx_state == COPY) || (nx_state == FLUSH);
            done   <= (state == FLUSH);
            dst_we <= (state == COPY);
            if (start)
                src_addr <= '0;
            else if (state == COPY)
                src_addr <= src_addr + 1'b1;
            if (state == COPY)
                dst_addr <= src_addr;
            if (dst_we)
                dout_hold <= src_data;
        end
    end

    // RAM data arrives one cycle after its address, i.e. in the write cycle itself
    assign dst_dout = dst_we ? src_data : dout_hold;

endmodule

// File: tb/tb_jtcop_objdma.sv
// Bench for jtcop_objdma: three instances (AW=4/no-wait, AW=4/vblank-wait, AW=2/no-wait) on shared stimulus.
module tb_jtcop_objdma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        copy = 1'b0;
    logic        lvbl = 1'b1;
    logic [3:0]  sa0, sa1, da0, da1;
    logic [1:0]  sa2, da2;
    logic [15:0] sd0, sd1, sd2, do0, do1, do2;
    logic [2:0]  we, bz, dn;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jtcop_objdma #(.AW(4), .WAIT_VB(1'b0)) u0 (
        .clk(clk), .rst(rst), .copy(copy), .LVBL(lvbl),
        .src_addr(sa0), .src_data(sd0), .dst_addr(da0), .dst_dout(do0),
        .dst_we(we[0]), .busy(bz[0]), .done(dn[0]));
    jtcop_objdma #(.AW(4), .WAIT_VB(1'b1)) u1 (
        .clk(clk), .rst(rst), .copy(copy), .LVBL(lvbl),
        .src_addr(sa1), .src_data(sd1), .dst_addr(da1), .dst_dout(do1),
        .dst_we(we[1]), .busy(bz[1]), .done(dn[1]));
    jtcop_objdma #(.AW(2), .WAIT_VB(1'b0)) u2 (
        .clk(clk), .rst(rst), .copy(copy), .LVBL(lvbl),
        .src_addr(sa2), .src_data(sd2), .dst_addr(da2), .dst_dout(do2),
        .dst_we(we[2]), .busy(bz[2]), .done(dn[2]));

    function automatic int ram_val(int i, int k);
        return (i == 2) ? 32'h5A00 + 3 * k : 32'hA000 + k;
    endfunction

    function automatic int nwords(int i);
        return (i == 2) ? 4 : 16;
    endfunction

    // Object RAMs with one cycle read latency
    always @(posedge clk) begin
        sd0 <= 16'(ram_val(0, int'(sa0)));
        sd1 <= 16'(ram_val(1, int'(sa1)));
        sd2 <= 16'(ram_val(2, int'(sa2)));
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_asrt++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is a progress count "phase" (-1 idle, 0..N-1 reading, N final write)
    typedef struct {
        int phase;
        bit pending;
        bit copy_l;
        bit done;
        int waddr;
        int wdata;
    } mst_t;

    mst_t ms[3];

    function automatic mst_t step(mst_t s, bit r, bit c, bit lv, int i);
        mst_t t = s;
        bit   start;
        int   n = nwords(i);
        if (r) begin
            t.phase = -1; t.pending = 0; t.copy_l = 0; t.done = 0; t.waddr = 0; t.wdata = 0;
            return t;
        end
        start  = (s.phase < 0) && s.pending && (i != 1 || !lv);
        t.done = (s.phase == n);
        if (s.phase >= 0)
            t.phase = (s.phase == n) ? -1 : s.phase + 1;
        else if (start)
            t.phase = 0;
        if (c && !s.copy_l)
            t.pending = 1;
        else if (start)
            t.pending = 0;
        t.copy_l = c;
        if (t.phase >= 1) begin
            t.waddr = t.phase - 1;
            t.wdata = ram_val(i, t.phase - 1);
        end
        return t;
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            ms[i] <= step(ms[i], rst, copy, lvbl, i);

    int busy_cnt[3], we_cnt[3], done_cnt[3], run_len[3], max_run[3];
    int wq_a[$], wq_d[$];
    int a_sa, a_da, a_do, e_sa;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin a_sa = int'(sa0); a_da = int'(da0); a_do = int'(do0); end
                1:       begin a_sa = int'(sa1); a_da = int'(da1); a_do = int'(do1); end
                default: begin a_sa = int'(sa2); a_da = int'(da2); a_do = int'(do2); end
            endcase
            e_sa = (ms[i].phase >= 0 && ms[i].phase < nwords(i)) ? ms[i].phase : 0;
            chk($sformatf("model busy u%0d", i), int'(bz[i]), int'(ms[i].phase >= 0));
            chk($sformatf("model dst_we u%0d", i), int'(we[i]), int'(ms[i].phase >= 1));
            chk($sformatf("model done u%0d", i), int'(dn[i]), int'(ms[i].done));
            chk($sformatf("model src_addr u%0d", i), a_sa, e_sa);
            chk($sformatf("model dst_addr u%0d", i), a_da, ms[i].waddr);
            chk($sformatf("model dst_dout u%0d", i), a_do, ms[i].wdata);
            if (bz[i]) busy_cnt[i]++;
            if (dn[i]) done_cnt[i]++;
            if (we[i]) begin
                we_cnt[i]++;
                run_len[i]++;
                if (run_len[i] > max_run[i]) max_run[i] = run_len[i];
            end else begin
                run_len[i] = 0;
            end
        end
        if (we[0]) begin
            wq_a.push_back(int'(da0));
            wq_d.push_back(int'(do0));
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0; we_cnt[i] = 0; done_cnt[i] = 0; run_len[i] = 0; max_run[i] = 0;
        end
        wq_a.delete();
        wq_d.delete();
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse();
        copy = 1'b1;
        @(posedge clk);
        #1 copy = 1'b0;
    endtask

    task automatic wait_we(input int i, input int target);
        int k = 0;
        while (we_cnt[i] < target && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk($sformatf("wait for write %0d u%0d", target, i), int'(we_cnt[i] >= target), 1);
    endtask

    typedef struct {
        bit rst, copy, lvbl;
        bit busy, we;
        int sa, da, dout;
        bit done;
    } vec_t;

    initial begin
        vec_t tbl[10];
        // AW=2 instance: reset, edge, transfer with address wrap, then quiet
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 'h0000, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 'h0000, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 'h5A00, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1, 'h5A03, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 2, 'h5A06, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 3, 'h5A09, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 'h5A09, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 'h5A09, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 'h5A09, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rst  = tbl[i].rst;
            copy = tbl[i].copy;
            lvbl = tbl[i].lvbl;
            @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("tbl[%0d] busy", i), int'(bz[2]), int'(tbl[i].busy));
            chk($sformatf("tbl[%0d] dst_we", i), int'(we[2]), int'(tbl[i].we));
            chk($sformatf("tbl[%0d] src_addr", i), int'(sa2), tbl[i].sa);
            chk($sformatf("tbl[%0d] dst_addr", i), int'(da2), tbl[i].da);
            chk($sformatf("tbl[%0d] dst_dout", i), int'(do2), tbl[i].dout);
            chk($sformatf("tbl[%0d] done", i), int'(dn[2]), int'(tbl[i].done));
        end
        run(40);

        // Basic copy on u0; u1 must stay parked while LVBL is high
        clear_counts();
        pulse();
        run(40);
        chk("basic busy cycles", busy_cnt[0], 17);
        chk("basic write count", we_cnt[0], 16);
        chk("basic consecutive writes", max_run[0], 16);
        chk("basic done pulses", done_cnt[0], 1);
        chk("vblank no write while LVBL high", we_cnt[1], 0);
        chk("basic write log size", wq_a.size(), 16);
        for (int k = 0; k < wq_a.size() && k < 16; k++) begin
            chk($sformatf("basic write %0d addr", k), wq_a[k], k);
            chk($sformatf("basic write %0d data", k), wq_d[k], 'hA000 + k);
        end

        // Vblank start and LVBL rising mid-transfer
        clear_counts();
        lvbl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("vblank busy after LVBL low", int'(bz[1]), 1);
        chk("vblank no write yet", int'(we[1]), 0);
        @(negedge clk);
        #1;
        chk("vblank first write we", int'(we[1]), 1);
        chk("vblank first write addr", int'(da1), 0);
        chk("vblank first write data", int'(do1), 'hA000);
        wait_we(1, 5);
        lvbl = 1'b1;
        run(40);
        chk("vblank total writes", we_cnt[1], 16);
        chk("vblank consecutive writes", max_run[1], 16);
        chk("vblank done pulses", done_cnt[1], 1);
        lvbl = 1'b0;

        // Held strobe gives a single transfer
        clear_counts();
        copy = 1'b1;
        run(6);
        copy = 1'b0;
        run(40);
        chk("held writes u0", we_cnt[0], 16);
        chk("held done u0", done_cnt[0], 1);
        chk("held writes u2", we_cnt[2], 4);
        chk("held done u2", done_cnt[2], 1);

        // Two edges during a transfer merge into one follow-up transfer
        clear_counts();
        pulse();
        wait_we(0, 8);
        pulse();
        wait_we(0, 10);
        pulse();
        run(60);
        chk("b2b writes u0", we_cnt[0], 32);
        chk("b2b done u0", done_cnt[0], 2);
        chk("b2b writes u1", we_cnt[1], 32);

        // Reset mid-copy aborts with no done
        clear_counts();
        pulse();
        wait_we(0, 7);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_counts();
        @(negedge clk);
        #1;
        chk("abort dst_we next cycle", int'(we[0]), 0);
        chk("abort busy next cycle", int'(bz[0]), 0);
        run(30);
        chk("abort no writes after", we_cnt[0], 0);
        chk("abort stays idle", busy_cnt[0], 0);
        chk("abort no done", done_cnt[0], 0);

        // copy already high at reset release counts as an edge
        copy = 1'b1;
        rst  = 1'b1;
        run(2);
        rst = 1'b0;
        clear_counts();
        run(40);
        chk("rst release edge writes", we_cnt[0], 16);
        chk("rst release edge done", done_cnt[0], 1);
        copy = 1'b0;
        run(5);

        // Random traffic against the model
        repeat (3000) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 19) == 0) copy = ~copy;
            if ($urandom_range(0, 29) == 0) lvbl = ~lvbl;
            rst = ($urandom_range(0, 399) == 0);
        end
        rst  = 1'b0;
        copy = 1'b0;
        lvbl = 1'b0;
        run(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
